round_tail: RTL and testbench
=============================

# round_tail

Registered back half of one AES encryption round, sitting directly downstream of the SubBytes stage. It takes the 128-bit SubBytes result, applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey with the supplied round key. It buffers results in a 2-entry output queue behind a valid/ready handshake, so the round controller can stall without losing a state.

## Interface
- No parameters; queue depth is fixed at 2.
- CLK  input  1  rising-edge clock
- RST  input  1  reset; asynchronous, active-high; clears all state
- IN_VALID  input  1  IN/KEY/LAST carry a state to accept
- IN_READY  output  1  queue can take a state this cycle
- IN  input  128  SubBytes output; IN[127:120] = byte 0
- KEY  input  128  round key, same byte order as IN
- LAST  input  1  final round: bypass MixColumns
- OUT_VALID  output  1  queue head valid
- OUT_READY  input  1  consumer takes head this cycle
- OUT  output  128  round result, same byte order
- OUT_LAST  output  1  LAST flag of the head entry

## Operation
- State layout: byte i (i = 0..15, byte 0 at IN[127:120]) is row i mod 4, column i div 4, column-major as in FIPS-197.
- ShiftRows: row r rotated left by r columns; row 0 unchanged.
- MixColumns per column (a0..a3) -> (2a0^3a1^a2^a3, a0^2a1^3a2^a3, a0^a1^2a2^3a3, 3a0^a1^a2^2a3) over GF(2^8), modulus 0x11B. xtime(b) = (b<<1)^(b[7]?0x1B:0), truncated to 8 bits. 3b = xtime(b)^b.
- Mixed = LAST ? ShiftRows(IN) : MixColumns(ShiftRows(IN)). Result = Mixed ^ KEY.
- The datapath is purely combinational from IN/KEY/LAST to the queue write port. Result and LAST are captured together on accept.
- Queue: 2 entries, count in {0,1,2}, write and read pointers each 1 bit, wrapping 1->0.
  - Push on IN_VALID && IN_READY.
  - Pop on OUT_VALID && OUT_READY.
- IN_READY = (count != 2), decoded from registered count only. No combinational path from OUT_READY.
- OUT_VALID = (count != 0). OUT/OUT_LAST come from the head entry register.
- Count transitions: push only -> +1. Pop only -> -1. Push and pop together -> unchanged, with both pointers advancing.
- Count 2: IN_READY = 0. Any IN_VALID is ignored and does not corrupt state. A pop this cycle raises IN_READY next cycle.
- Count 0: OUT_READY is ignored. Pointers do not move.
- While OUT_VALID && !OUT_READY, OUT and OUT_LAST stay stable.
- Reset mid-operation: queued entries are discarded immediately. No partial result emerges after release.

## Timing
- Reset values: OUT_VALID = 0, OUT = 128'h0, OUT_LAST = 0, count = 0, pointers = 0, IN_READY = 1 (count is 0).
- Latency: a state accepted at edge N, with the queue empty, appears on OUT with OUT_VALID = 1 after edge N, i.e. in cycle N+1.
- Throughput: 1 state/cycle while OUT_READY is held high. Count then stays at 1 under a continuous stream.
- With OUT_READY low, two states are absorbed. IN_READY drops in the cycle after the second accept.
- Entries are unoccupied slots zeroed only by reset. Their content is a don't-care when OUT_VALID = 0.

## Test plan
- Round 1 (FIPS-197 App. B): IN = d42711aee0bf98f1b8b45de51e415230, KEY = a0fafe1788542cb123a339392a6c7605, LAST = 0, OUT_READY = 1. Required: next cycle OUT = a49c7ff2689f352b6b5bea43026a5049, OUT_VALID = 1, OUT_LAST = 0.
- Final round: IN = e9098972cb31075f3d327d94af2e2cb5, KEY = d014f9a8c9ee2589e13f0cc8b6630ca6, LAST = 1. Required: OUT = 3925841d02dc09fbdc118597196a0b32, OUT_LAST = 1.
- Backpressure: OUT_READY = 0, push A, B, C on consecutive cycles. Required:
  - A and B accepted; IN_READY = 0 when C is offered; C is not accepted.
  - OUT stays at result(A).
  - Raising OUT_READY yields A, then B, in order, with IN_READY returning to 1 one cycle after the first pop.
- Streaming: 16 back-to-back states with OUT_READY = 1. Required: 16 results in order, one per cycle, with count never exceeding 1.
- Simultaneous push/pop at count 1: count stays 1. The old head leaves and the new state becomes head on the next cycle.
- Reset with 2 entries queued: assert RST asynchronously mid-cycle. Required: OUT_VALID = 0, OUT = 0, and IN_READY = 1 immediately. After release, no stale entry is output.

Source files
------------

// File: rtl/round_tail.sv
// round_tail: ShiftRows, MixColumns (skipped on the final round) and AddRoundKey
// of one AES encryption round, buffered in a two-entry valid/ready output queue.
module round_tail (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN,
    input  logic [127:0] KEY,
    input  logic         LAST,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT,
    output logic         OUT_LAST
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // One state column, byte a0 in the top bits.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (row + 4 * c) -: 8] = s[127 - 8 * (row + 4 * ((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32 * c -: 32] = mix_column(s[127 - 32 * c -: 32]);
        end
        return r;
    endfunction

    logic [127:0] shifted_s;
    logic [127:0] mixed_s;
    logic [127:0] result_s;
    logic         push_s;
    logic         pop_s;

    // Each entry holds {LAST, result}; slots are cleared only by reset.
    logic [128:0] mem_q [2];
    logic [128:0] mem_d [2];
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         wr_ptr_q;
    logic         wr_ptr_d;
    logic         rd_ptr_q;
    logic         rd_ptr_d;

    // Round datapath from SubBytes output to the queue write port.
    always_comb begin
        shifted_s = shift_rows(IN);
        if (LAST) begin
            mixed_s = shifted_s;
        end else begin
            mixed_s = mix_columns(shifted_s);
        end
        result_s = mixed_s ^ KEY;
    end

    // Queue next-state: push/pop decode, pointer advance and occupancy.
    always_comb begin
        push_s   = IN_VALID && (count_q != 2'd2);
        pop_s    = OUT_READY && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {LAST, result_s};
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Queue storage, pointers and count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= 129'h0;
            end
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Handshake flags decode registered occupancy only; data comes from the head slot.
    assign IN_READY  = (count_q != 2'd2);
    assign OUT_VALID = (count_q != 2'd0);
    assign OUT       = mem_q[rd_ptr_q][127:0];
    assign OUT_LAST  = mem_q[rd_ptr_q][128];

endmodule

// File: tb/tb_round_tail.sv
// Self-checking bench for round_tail: FIPS-197 vector table, a reference model
// feeding a scoreboard, and hand-written backpressure/stream/reset sequences.
module tb_round_tail;

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [127:0] IN;
    logic [127:0] KEY;
    logic         LAST;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [127:0] OUT;
    logic         OUT_LAST;

    always #5 CLK = ~CLK;

    round_tail dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN(IN), .KEY(KEY), .LAST(LAST), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT(OUT), .OUT_LAST(OUT_LAST)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [128:0] exp_q[$];

    typedef struct {
        logic [127:0] din;
        logic [127:0] key;
        logic         last;
        logic [127:0] dout;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // GF(2^8) shift-and-add multiply, modulus 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0] st[4][4];
        logic [7:0] sh[4][4];
        logic [7:0] mx;
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                st[w][c] = s[127 - 8 * (w + 4 * c) -: 8];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                sh[w][c] = st[w][(c + w) % 4];
        r = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                if (last) mx = sh[w][c];
                else mx = gmul(8'h02, sh[w][c]) ^ gmul(8'h03, sh[(w + 1) % 4][c])
                          ^ sh[(w + 2) % 4][c] ^ sh[(w + 3) % 4][c];
                r[127 - 8 * (w + 4 * c) -: 8] = mx ^ k[127 - 8 * (w + 4 * c) -: 8];
            end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: pop-and-compare on output handshake, push on input handshake.
    always @(negedge CLK) begin
        logic [128:0] e;
        if (RST) begin
            exp_q.delete();
        end else begin
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_spurious: got %h want no output", OUT);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_out", OUT, e[127:0]);
                    chk("sb_last", OUT_LAST, e[128]);
                end
            end
            if (IN_VALID && IN_READY) exp_q.push_back({LAST, model(IN, KEY, LAST)});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic [127:0] k, input logic l);
        IN_VALID = v;
        IN       = d;
        KEY      = k;
        LAST     = l;
    endtask

    initial begin
        logic [127:0] a_d, a_k, b_d, b_k, c_d, c_k, exp_a, exp_b, exp_y;

        tbl[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
                   1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049};
        tbl[1] = '{128'he9098972cb31075f3d327d94af2e2cb5, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                   1'b1, 128'h3925841d02dc09fbdc118597196a0b32};
        for (int i = 2; i < 6; i++) begin
            tbl[i].din  = rnd128();
            tbl[i].key  = rnd128();
            tbl[i].last = i[0];
            tbl[i].dout = model(tbl[i].din, tbl[i].key, tbl[i].last);
        end

        RST = 1'b1;
        OUT_READY = 1'b0;
        drive(1'b0, 128'h0, 128'h0, 1'b0);
        #1;
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_out", OUT, 128'h0);
        chk("rst_out_last", OUT_LAST, 1'b0);
        chk("rst_in_ready", IN_READY, 1'b1);
        step();
        step();
        RST = 1'b0;
        step();

        // Table: one vector per cycle, result visible one cycle after accept.
        OUT_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tbl[i].din, tbl[i].key, tbl[i].last);
            step();
            chk("tbl_valid", OUT_VALID, 1'b1);
            chk("tbl_out", OUT, tbl[i].dout);
            chk("tbl_last", OUT_LAST, tbl[i].last);
        end
        drive(1'b0, 128'h0, 128'h0, 1'b0);
        step();
        chk("tbl_drained", OUT_VALID, 1'b0);

        // Backpressure: A and B absorbed, C refused, then A, B drain in order.
        a_d = rnd128(); a_k = rnd128(); b_d = rnd128(); b_k = rnd128();
        c_d = rnd128(); c_k = rnd128();
        exp_a = model(a_d, a_k, 1'b0);
        exp_b = model(b_d, b_k, 1'b1);
        OUT_READY = 1'b0;
        drive(1'b1, a_d, a_k, 1'b0);
        step();
        chk("bp_ready_after_a", IN_READY, 1'b1);
        drive(1'b1, b_d, b_k, 1'b1);
        step();
        chk("bp_ready_after_b", IN_READY, 1'b0);
        chk("bp_head_a", OUT, exp_a);
        drive(1'b1, c_d, c_k, 1'b0);
        step();
        chk("bp_c_refused", IN_READY, 1'b0);
        chk("bp_stable_a", OUT, exp_a);
        chk("bp_stable_last", OUT_LAST, 1'b0);
        drive(1'b0, 128'h0, 128'h0, 1'b0);
        OUT_READY = 1'b1;
        step();
        chk("bp_ready_back", IN_READY, 1'b1);
        chk("bp_head_b", OUT, exp_b);
        chk("bp_head_b_last", OUT_LAST, 1'b1);
        step();
        chk("bp_empty", OUT_VALID, 1'b0);

        // Streaming: 16 back-to-back states, occupancy never reaches 2.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, rnd128(), rnd128(), i[2]);
            step();
            chk("stream_ready", IN_READY, 1'b1);
            chk("stream_valid", OUT_VALID, 1'b1);
        end
        drive(1'b0, 128'h0, 128'h0, 1'b0);
        step();
        chk("stream_drained", OUT_VALID, 1'b0);

        // Simultaneous push and pop at count 1.
        OUT_READY = 1'b0;
        drive(1'b1, a_d, a_k, 1'b1);
        step();
        exp_y = model(c_d, c_k, 1'b0);
        OUT_READY = 1'b1;
        drive(1'b1, c_d, c_k, 1'b0);
        step();
        chk("pp_head_new", OUT, exp_y);
        chk("pp_ready", IN_READY, 1'b1);
        chk("pp_valid", OUT_VALID, 1'b1);
        drive(1'b0, 128'h0, 128'h0, 1'b0);
        step();
        chk("pp_drained", OUT_VALID, 1'b0);

        // Asynchronous reset with two entries queued.
        OUT_READY = 1'b0;
        drive(1'b1, a_d, a_k, 1'b1);
        step();
        drive(1'b1, b_d, b_k, 1'b1);
        step();
        drive(1'b0, 128'h0, 128'h0, 1'b0);
        chk("ar_full", IN_READY, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_out_valid", OUT_VALID, 1'b0);
        chk("ar_out", OUT, 128'h0);
        chk("ar_in_ready", IN_READY, 1'b1);
        step();
        RST = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar_no_stale", OUT_VALID, 1'b0);
        end
        drive(1'b1, tbl[0].din, tbl[0].key, tbl[0].last);
        step();
        chk("ar_resume", OUT, tbl[0].dout);
        drive(1'b0, 128'h0, 128'h0, 1'b0);
        step();
        step();

        chk("sb_leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
